// File: rtl/cmu_req_arbiter_if.sv
// Requester and CMU CPU-side signal bundle for the CMU request arbiter.
// Latency: none; wires only.
// Backpressure: cmu_stall travels CMU->arbiter, and req_ack travels arbiter->requester.
interface cmu_req_arbiter_if #(
    parameter int NUM_CH = 3
);
    // Requester side: one slice per channel, packed side by side
    logic [NUM_CH-1:0]    req_ren;
    logic [NUM_CH-1:0]    req_wen;
    logic [NUM_CH-1:0]    req_flush;
    logic [NUM_CH-1:0]    req_en_cache;
    logic [NUM_CH-1:0]    req_ext;
    logic [NUM_CH-1:0]    req_lock;
    logic [2*NUM_CH-1:0]  req_type;
    logic [32*NUM_CH-1:0] req_addr;
    logic [32*NUM_CH-1:0] req_data_w;
    logic [NUM_CH-1:0]    req_ack;
    logic [31:0]          req_data_r;
    logic [NUM_CH-1:0]    gnt;
    logic                 lock_err;

    // CMU side: the single shared port
    logic                 cmu_en_cache;
    logic                 cmu_sign_ext;
    logic                 cmu_en_r;
    logic                 cmu_en_w;
    logic                 cmu_en_f;
    logic                 cmu_lock;
    logic [1:0]           cmu_addr_type;
    logic [31:0]          cmu_addr_rw;
    logic [31:0]          cmu_data_w;
    logic [31:0]          cmu_data_r;
    logic                 cmu_stall;

    // Environment view: drives the requests and the CMU responses
    modport master (
        output req_ren, req_wen, req_flush, req_en_cache, req_ext, req_lock,
               req_type, req_addr, req_data_w, cmu_data_r, cmu_stall,
        input  req_ack, req_data_r, gnt, lock_err,
               cmu_en_cache, cmu_sign_ext, cmu_en_r, cmu_en_w, cmu_en_f,
               cmu_lock, cmu_addr_type, cmu_addr_rw, cmu_data_w
    );

    // Arbiter view
    modport slave (
        input  req_ren, req_wen, req_flush, req_en_cache, req_ext, req_lock,
               req_type, req_addr, req_data_w, cmu_data_r, cmu_stall,
        output req_ack, req_data_r, gnt, lock_err,
               cmu_en_cache, cmu_sign_ext, cmu_en_r, cmu_en_w, cmu_en_f,
               cmu_lock, cmu_addr_type, cmu_addr_rw, cmu_data_w
    );
endinterface

// File: rtl/cmu_req_arbiter.sv
// N-channel arbiter sharing one CMU CPU-side port, with held grants, bus lock and lock watchdog.
// Latency: zero added cycles; an idle arbiter forwards the winner and acks it in the same cycle.
// Backpressure: cmu_stall holds the current owner (no preemption) until the CMU accepts or the request is withdrawn.
module cmu_req_arbiter #(
    parameter int NUM_CH       = 3,
    parameter int ARB_MODE     = 0,
    parameter int LOCK_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    cmu_req_arbiter_if.slave  bus
);
    localparam int CW = $clog2(NUM_CH);
    localparam int WW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_BUSY_LK = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     own, own_nxt;
    logic [CW-1:0]     ptr, ptr_nxt;
    logic [CW-1:0]     blk_ch, blk_ch_nxt;
    logic              blk, blk_nxt;
    logic [WW-1:0]     wd_cnt, wd_cnt_nxt;
    logic [CW-1:0]     win, cur;
    logic [CW:0]       rr_idx;
    logic              win_vld, active, cur_req, ack, wd_fire;
    logic [NUM_CH-1:0] req_any, lock_eff;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign req_any = bus.req_ren | bus.req_wen | bus.req_flush;
    // A lock that timed out is ignored until its owner drops req_lock
    assign lock_eff = bus.req_lock & ~(blk ? onehot(blk_ch) : '0);

    // Winner search: from channel 0 (fixed) or from ptr with wrap (round-robin); lowest offset wins
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        rr_idx  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ARB_MODE == 1) rr_idx = {1'b0, ptr} + (CW+1)'(k);
            else               rr_idx = (CW+1)'(k);
            if (rr_idx >= (CW+1)'(NUM_CH)) rr_idx = rr_idx - (CW+1)'(NUM_CH);
            if (req_any[rr_idx[CW-1:0]]) begin
                win     = rr_idx[CW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    // Ownership FSM next state, ack generation and lock watchdog
    always_comb begin
        state_nxt  = state;
        own_nxt    = own;
        ptr_nxt    = ptr;
        blk_nxt    = blk;
        blk_ch_nxt = blk_ch;
        wd_cnt_nxt = wd_cnt;
        wd_fire    = 1'b0;
        cur        = own;
        active     = 1'b0;
        cur_req    = 1'b0;
        ack        = 1'b0;

        if (blk && !bus.req_lock[blk_ch]) blk_nxt = 1'b0;

        if (state == ST_IDLE) begin
            cur    = win;
            active = win_vld;
        end else begin
            active = 1'b1;
        end
        // Reset aborts an in-flight transfer immediately: nothing granted, nothing acked
        if (rst) active = 1'b0;
        cur_req = active & req_any[cur];
        ack     = cur_req & ~bus.cmu_stall;

        case (state)
            ST_IDLE: begin
                if (win_vld) begin
                    own_nxt = win;
                    if (bus.cmu_stall) state_nxt = ST_BUSY;
                    else               state_nxt = lock_eff[win] ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_BUSY, ST_BUSY_LK: begin
                // Completion or withdrawal both end the transfer; lock decides where we land
                if (!req_any[own] || !bus.cmu_stall)
                    state_nxt = lock_eff[own] ? ST_LOCKED : ST_IDLE;
            end
            ST_LOCKED: begin
                if (req_any[own]) begin
                    wd_cnt_nxt = '0;
                    if (bus.cmu_stall) state_nxt = ST_BUSY_LK;
                    else               state_nxt = lock_eff[own] ? ST_LOCKED : ST_IDLE;
                end else if (!lock_eff[own]) begin
                    state_nxt = ST_IDLE;
                end else if (LOCK_TIMEOUT != 0) begin
                    // Counter reaching LOCK_TIMEOUT this cycle fires; it never counts past that
                    if (wd_cnt >= WW'(LOCK_TIMEOUT - 1)) begin
                        wd_fire    = 1'b1;
                        state_nxt  = ST_IDLE;
                        blk_nxt    = 1'b1;
                        blk_ch_nxt = own;
                    end else begin
                        wd_cnt_nxt = wd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (state_nxt != ST_LOCKED && state_nxt != ST_BUSY_LK) wd_cnt_nxt = '0;
        if (ack) ptr_nxt = (cur == CW'(NUM_CH - 1)) ? '0 : cur + 1'b1;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            own    <= '0;
            ptr    <= '0;
            blk    <= 1'b0;
            blk_ch <= '0;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            own    <= own_nxt;
            ptr    <= ptr_nxt;
            blk    <= blk_nxt;
            blk_ch <= blk_ch_nxt;
            wd_cnt <= wd_cnt_nxt;
        end
    end

    assign bus.req_ack       = ack ? onehot(cur) : '0;
    assign bus.gnt           = active ? onehot(cur) : '0;
    assign bus.req_data_r    = active ? bus.cmu_data_r : '0;
    assign bus.lock_err      = wd_fire;
    assign bus.cmu_en_r      = cur_req & bus.req_ren[cur];
    assign bus.cmu_en_w      = cur_req & bus.req_wen[cur];
    assign bus.cmu_en_f      = cur_req & bus.req_flush[cur];
    assign bus.cmu_en_cache  = cur_req & bus.req_en_cache[cur];
    assign bus.cmu_sign_ext  = cur_req & bus.req_ext[cur];
    assign bus.cmu_lock      = active & ((state == ST_LOCKED) || (state == ST_BUSY_LK) || lock_eff[cur]);
    assign bus.cmu_addr_type = cur_req ? bus.req_type[2*cur +: 2]    : '0;
    assign bus.cmu_addr_rw   = cur_req ? bus.req_addr[32*cur +: 32]   : '0;
    assign bus.cmu_data_w    = cur_req ? bus.req_data_w[32*cur +: 32] : '0;
endmodule

// File: doc/cmu_req_arbiter.md
# cmu_req_arbiter

Parametrised N-channel request arbiter that shares one cache-management-unit (CMU) CPU-side port among several requesters, such as the instruction TLB walker, the data TLB walker and the data memory stage. It replaces the fixed-priority combinational mux in front of the data CMU. It adds:
- registered grant ownership held across stalls;
- selectable fixed-priority or round-robin arbitration;
- bus-lock ownership with a watchdog timeout.

It sits between the requesters and one `wb_cmu`/`wb_cpu_conn` instance.

## Interface
Parameters:
- NUM_CH, 3, number of requester channels (2..8); channel 0 is highest priority in fixed mode.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- LOCK_TIMEOUT, 256, maximum cycles a lock may be held idle; 0 disables the watchdog.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset, asynchronous, active-high.
- req_ren  in  NUM_CH  per-channel read request.
- req_wen  in  NUM_CH  per-channel write request.
- req_flush  in  NUM_CH  per-channel cache flush request.
- req_en_cache  in  NUM_CH  per-channel cacheable flag.
- req_ext  in  NUM_CH  per-channel sign-extend flag.
- req_lock  in  NUM_CH  per-channel lock request.
- req_type  in  2*NUM_CH  per-channel access type (MEM_TYPE_*); channel i occupies [2i+1:2i].
- req_addr  in  32*NUM_CH  per-channel address; channel i occupies [32i+31:32i].
- req_data_w  in  32*NUM_CH  per-channel write data.
- req_ack  out  NUM_CH  one-hot completion pulse.
- req_data_r  out  32  read data, valid in the cycle of the ack.
- gnt  out  NUM_CH  one-hot current owner; 0 when there is no owner.
- lock_err  out  1  one-cycle pulse when the lock watchdog fires.
- cmu_en_cache, cmu_sign_ext, cmu_en_r, cmu_en_w, cmu_en_f, cmu_lock  out  1 each  forwarded to the CMU.
- cmu_addr_type  out  2  forwarded to the CMU.
- cmu_addr_rw  out  32  forwarded to the CMU.
- cmu_data_w  out  32  forwarded to the CMU.
- cmu_data_r  in  32  read data from the CMU.
- cmu_stall  in  1  CMU busy.

## Operation
Request definition:
- req_any[i] = req_ren[i] | req_wen[i] | req_flush[i].

State machine, with a registered owner index `own` and a registered `held` flag:
- IDLE (held=0)
  - The winner w is computed combinationally from req_any.
  - Channel w's signals are forwarded to the CMU in the same cycle, and gnt = onehot(w).
  - If cmu_stall=0: req_ack[w]=1. Next state is LOCKED(w) if req_lock[w], else IDLE.
  - If cmu_stall=1: next state is BUSY(w).
  - With no request, all cmu_* outputs are 0.
- BUSY(w)
  - Channel w is forwarded regardless of other requests; there is no preemption, even by a higher priority channel.
  - If cmu_stall=0: req_ack[w]=1. Next state is LOCKED(w) if req_lock[w], else IDLE.
  - If req_any[w]=0 (request withdrawn, e.g. on an exception): the cmu_en_* outputs are 0, there is no ack, and the next state is IDLE, or LOCKED(w) if req_lock[w].
- LOCKED(w)
  - Only channel w may be granted; other requests wait.
  - gnt = onehot(w) and cmu_lock = 1.
  - A request from w is handled as in IDLE/BUSY, but the state remains LOCKED/BUSY-locked.
  - When req_lock[w] drops: return to IDLE if the state is idle; if the state is BUSY-locked, finish the transfer first.
- Watchdog
  - A counter increments every cycle in LOCKED(w) with req_any[w]=0 and resets on any request from w.
  - When the counter reaches LOCK_TIMEOUT: lock_err pulses for one cycle and the state is forced to IDLE.
  - The lock is then ignored until req_lock[w] deasserts.

Arbitration:
- Fixed mode: the lowest set index of req_any wins.
- Round-robin mode: the search starts at pointer `ptr` and wraps at NUM_CH. On every ack of channel w, ptr = (w+1) mod NUM_CH, with wrap from NUM_CH-1 to 0.
- ptr is unused in fixed mode.

Data and ack:
- req_data_r = cmu_data_r whenever a grant exists; otherwise 0.
- req_ack has at most one bit set per cycle.

## Timing
- Reset values:
  - all req_ack, gnt, cmu_* outputs and req_data_r are 0;
  - lock_err = 0;
  - state = IDLE, ptr = 0, watchdog counter = 0.
- Reset asserted mid-transfer aborts immediately with no ack.
- Latency: zero added cycles. A request to an idle arbiter with cmu_stall=0 is acked in the same cycle.
- Requesters hold their inputs stable until ack or withdrawal.
- Simultaneous ack and new request from another channel: the new owner is taken from the next cycle, using the updated ptr.
- Watchdog behaviour:
  - A request from w in the same cycle the counter reaches LOCK_TIMEOUT is honored, the counter resets, and there is no lock_err.
  - The counter saturates and never wraps.

## Test plan
- NUM_CH=3, ARB_MODE=0, ch1 and ch2 read in the same cycle with cmu_stall=0 → req_ack=3'b010 in cycle 0. ch2 is acked in cycle 1 and cmu_addr_rw = req_addr[95:64].
- ARB_MODE=1, all 3 channels reading continuously with no stall → acks rotate 001, 010, 100, 001; ptr wraps from 2 to 0.
- ch2 granted with cmu_stall held high 4 cycles while ch0 requests → gnt stays 100 for 4 cycles. ch2 is acked on the 5th cycle and ch0 is granted the following cycle.
- ch1 withdraws its request during the 2nd stall cycle → no ack, gnt=0 the next cycle, and cmu_en_r low.
- ch0 locks and does read then write while ch1 requests → ch1 is not granted until req_lock[0] drops. cmu_lock=1 throughout.
- LOCK_TIMEOUT=4, ch0 locked and idle → lock_err pulses on the 4th idle cycle and a waiting ch1 is acked the next cycle.
